option_bundle_source: RTL and testbench

- Transmitter for the optional-field bundle stream: {bar: 1b, foo: FOO_W bits, present only when HAS_FOO=1}.
- On a start request it emits a fixed-length, deterministic beat sequence over a valid/ready interface, then reports completion.
- It drives the same bundle that the optional-bundle checker consumes, so the checker can end simulation on a known pattern.
- Serves as the stimulus end of both configurations: field present and field absent.

---
 rtl/option_bundle_source.sv | 102 ++++++++++
 tb/tb_option_bundle_source.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/option_bundle_source.sv
// Optional-field bundle source: emits NUM_BEATS beats of {bar, foo} over valid/ready
// after a start request, then parks in DONE until the next start.
module option_bundle_source #(
   parameter int unsigned HAS_FOO   = 1,
   parameter int unsigned FOO_W     = 8,
   parameter int unsigned NUM_BEATS = 16,
   parameter int unsigned CW        = $clog2(NUM_BEATS + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [FOO_W-1:0] seed,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bar,
   output logic [FOO_W-1:0] out_foo,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    beat_count
);

   typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

   localparam logic [CW-1:0] LastIdx = CW'(NUM_BEATS - 1);

   state_e             state_q, state_d;
   logic               valid_q, valid_d;
   logic               bar_q, bar_d;
   logic [FOO_W-1:0]   foo_q, foo_d;
   logic [FOO_W-1:0]   seed_q, seed_d;
   logic [CW-1:0]      count_q, count_d;
   logic [CW-1:0]      count_inc;
   logic               handshake;

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      bar_d     = bar_q;
      foo_d     = foo_q;
      seed_d    = seed_q;
      count_d   = count_q;
      count_inc = count_q + CW'(1);
      handshake = valid_q & out_ready;

      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StSend;
               seed_d  = (HAS_FOO != 0) ? seed : '0;
               count_d = '0;
               valid_d = 1'b1;
               bar_d   = 1'b0;
               foo_d   = (HAS_FOO != 0) ? seed : '0;
            end
         end
         StSend: begin
            if (handshake) begin
               count_d = count_inc;
            end
            // A handshake coinciding with abort still counts; the beat index is the count.
            if (abort || (handshake && (count_q == LastIdx))) begin
               state_d = StDone;
               valid_d = 1'b0;
            end else if (handshake) begin
               bar_d = count_inc[0];
               foo_d = (HAS_FOO != 0) ? seed_q + FOO_W'(count_inc) : '0;
            end
         end
         default: begin
            state_d = StIdle;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         valid_q <= 1'b0;
         bar_q   <= 1'b0;
         foo_q   <= '0;
         seed_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         bar_q   <= bar_d;
         foo_q   <= foo_d;
         seed_q  <= seed_d;
         count_q <= count_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_bar    = bar_q;
   assign out_foo    = foo_q;
   assign busy       = (state_q == StSend);
   assign done       = (state_q == StDone);
   assign beat_count = count_q;

endmodule

// File: tb/tb_option_bundle_source.sv
// Directed bench for option_bundle_source: three instances cover the 16-beat, 8-beat wrap
// and foo-absent configurations.
module tb_option_bundle_source;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // Instance A: HAS_FOO=1, FOO_W=8, NUM_BEATS=16
   logic       a_reset, a_start, a_abort, a_ready;
   logic [7:0] a_seed;
   logic       a_valid, a_bar, a_busy, a_done;
   logic [7:0] a_foo;
   logic [4:0] a_count;

   // Instance B: HAS_FOO=1, FOO_W=8, NUM_BEATS=8
   logic       b_reset, b_start, b_abort, b_ready;
   logic [7:0] b_seed;
   logic       b_valid, b_bar, b_busy, b_done;
   logic [7:0] b_foo;
   logic [3:0] b_count;

   // Instance C: HAS_FOO=0, FOO_W=8, NUM_BEATS=4
   logic       c_reset, c_start, c_abort, c_ready;
   logic [7:0] c_seed;
   logic       c_valid, c_bar, c_busy, c_done;
   logic [7:0] c_foo;
   logic [2:0] c_count;

   option_bundle_source #(.HAS_FOO(1), .FOO_W(8), .NUM_BEATS(16)) dut_a (
      .clock(clock), .reset(a_reset), .start(a_start), .seed(a_seed), .abort(a_abort),
      .out_valid(a_valid), .out_ready(a_ready), .out_bar(a_bar), .out_foo(a_foo),
      .busy(a_busy), .done(a_done), .beat_count(a_count)
   );

   option_bundle_source #(.HAS_FOO(1), .FOO_W(8), .NUM_BEATS(8)) dut_b (
      .clock(clock), .reset(b_reset), .start(b_start), .seed(b_seed), .abort(b_abort),
      .out_valid(b_valid), .out_ready(b_ready), .out_bar(b_bar), .out_foo(b_foo),
      .busy(b_busy), .done(b_done), .beat_count(b_count)
   );

   option_bundle_source #(.HAS_FOO(0), .FOO_W(8), .NUM_BEATS(4)) dut_c (
      .clock(clock), .reset(c_reset), .start(c_start), .seed(c_seed), .abort(c_abort),
      .out_valid(c_valid), .out_ready(c_ready), .out_bar(c_bar), .out_foo(c_foo),
      .busy(c_busy), .done(c_done), .beat_count(c_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_a_reset_state(input string tag);
      check({tag, " valid"}, a_valid, 0);
      check({tag, " bar"},   a_bar,   0);
      check({tag, " foo"},   a_foo,   0);
      check({tag, " busy"},  a_busy,  0);
      check({tag, " done"},  a_done,  0);
      check({tag, " count"}, a_count, 0);
   endtask

   logic [7:0] wrap_exp [8];
   logic [7:0] e;
   int         k;
   int         cyc;

   initial begin
      wrap_exp = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
      a_reset = 1; a_start = 0; a_abort = 0; a_ready = 1; a_seed = 0;
      b_reset = 1; b_start = 0; b_abort = 0; b_ready = 1; b_seed = 0;
      c_reset = 1; c_start = 0; c_abort = 0; c_ready = 1; c_seed = 8'hAA;
      tick();
      tick();
      a_reset = 0; b_reset = 0; c_reset = 0;
      check_a_reset_state("a_reset");

      // Full 16-beat run, seed 0x10, no backpressure
      a_seed = 8'h10; a_start = 1;
      check("a_valid_before_start", a_valid, 0);
      tick();
      a_start = 0;
      check("a_valid_after_start", a_valid, 1);
      check("a_busy_send", a_busy, 1);
      check("a_count_cleared", a_count, 0);
      for (int i = 0; i < 16; i++) begin
         e = 8'h10 + 8'(i);
         check("a_run_valid", a_valid, 1);
         check("a_run_foo", a_foo, e);
         check("a_run_bar", a_bar, i % 2);
         tick();
      end
      check("a_run_done", a_done, 1);
      check("a_run_valid_off", a_valid, 0);
      check("a_run_busy_off", a_busy, 0);
      check("a_run_count", a_count, 16);

      // Random backpressure, seed 0x40: data must hold while stalled and never skip
      a_seed = 8'h40; a_start = 1;
      tick();
      a_start = 0;
      k = 0;
      cyc = 0;
      while (k < 16 && cyc < 300) begin
         a_ready = 1'($urandom_range(0, 1));
         e = 8'h40 + 8'(k);
         check("bp_valid", a_valid, 1);
         check("bp_foo", a_foo, e);
         check("bp_bar", a_bar, k % 2);
         if (a_ready) k++;
         tick();
         cyc++;
      end
      a_ready = 1;
      check("bp_transfers_within_budget", k, 16);
      check("bp_done", a_done, 1);
      check("bp_count", a_count, 16);

      // Abort coinciding with the 5th handshake
      a_seed = 8'h20; a_start = 1;
      tick();
      a_start = 0;
      check("ab_done_dropped", a_done, 0);
      check("ab_count_cleared", a_count, 0);
      tick(); tick(); tick(); tick();
      check("ab_beat4_foo", a_foo, 8'h24);
      check("ab_count4", a_count, 4);
      a_abort = 1;
      tick();
      a_abort = 0;
      check("ab_done", a_done, 1);
      check("ab_valid_off", a_valid, 0);
      check("ab_count5", a_count, 5);
      a_abort = 1;
      tick();
      a_abort = 0;
      check("ab_in_done_done", a_done, 1);
      check("ab_in_done_count", a_count, 5);
      check("ab_in_done_busy", a_busy, 0);

      // Restart from DONE with seed 0
      a_seed = 8'h00; a_start = 1;
      tick();
      a_start = 0;
      check("rs_count", a_count, 0);
      check("rs_valid", a_valid, 1);
      check("rs_foo", a_foo, 0);
      check("rs_bar", a_bar, 0);
      check("rs_done", a_done, 0);

      // Reset at beat 3 drops the in-flight beat
      tick(); tick(); tick();
      check("rst_beat3_foo", a_foo, 3);
      check("rst_beat3_count", a_count, 3);
      a_reset = 1;
      tick();
      a_reset = 0;
      check_a_reset_state("a_midreset");
      tick(); tick();
      a_seed = 8'h05; a_start = 1;
      tick();
      a_start = 0;
      for (int i = 0; i < 16; i++) begin
         e = 8'h05 + 8'(i);
         check("post_rst_valid", a_valid, 1);
         check("post_rst_foo", a_foo, e);
         check("post_rst_bar", a_bar, i % 2);
         tick();
      end
      check("post_rst_done", a_done, 1);
      check("post_rst_count", a_count, 16);

      // Instance B: foo wraps past 0xFF
      b_seed = 8'hFC; b_start = 1;
      tick();
      b_start = 0;
      for (int i = 0; i < 8; i++) begin
         check("wrap_valid", b_valid, 1);
         check("wrap_foo", b_foo, wrap_exp[i]);
         check("wrap_bar", b_bar, i % 2);
         tick();
      end
      check("wrap_done", b_done, 1);
      check("wrap_count", b_count, 8);
      check("wrap_valid_off", b_valid, 0);

      // Instance C: foo absent, start during SEND ignored
      c_start = 1;
      tick();
      c_start = 0;
      for (int i = 0; i < 4; i++) begin
         check("nofoo_valid", c_valid, 1);
         check("nofoo_foo", c_foo, 0);
         check("nofoo_bar", c_bar, i % 2);
         c_start = (i == 1) ? 1'b1 : 1'b0;
         tick();
      end
      c_start = 0;
      check("nofoo_done", c_done, 1);
      check("nofoo_count", c_count, 4);
      check("nofoo_valid_off", c_valid, 0);
      tick();
      check("nofoo_count_hold", c_count, 4);
      check("nofoo_foo_hold", c_foo, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
